// File: rtl/vec_stream_ctrl_if.sv
`timescale 1ns/1ps
// vec_stream_ctrl_if: run handshake plus BRAM read/write address and enable bundle.
// rd_stride/wr_stride exist only when VEC_STREAM_CTRL_STRIDE_EN is defined.
interface vec_stream_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
`ifdef VEC_STREAM_CTRL_STRIDE_EN
    logic [ADDR_W-1:0] rd_stride;
    logic [ADDR_W-1:0] wr_stride;
`endif
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output start, len, rd_base, wr_base,
`ifdef VEC_STREAM_CTRL_STRIDE_EN
        output rd_stride, wr_stride,
`endif
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr
    );

    modport slave (
        input  start, len, rd_base, wr_base,
`ifdef VEC_STREAM_CTRL_STRIDE_EN
        input  rd_stride, wr_stride,
`endif
        output busy, done, rd_en, rd_addr, wr_en, wr_addr
    );
endinterface

// File: rtl/vec_stream_ctrl.sv
`timescale 1ns/1ps
// vec_stream_ctrl: streams element reads from a source region and delayed writes to a destination.
// Define VEC_STREAM_CTRL_STRIDE_EN to add per-run read/write strides (otherwise stride is 1).
module vec_stream_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    vec_stream_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_k;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [LEN_W-1:0]  r_pipe_idx [RD_LAT];

    logic [ADDR_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_ws;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_wr_off;
    logic              w_issue;
    logic [LEN_W-1:0]  w_issue_idx;

`ifdef VEC_STREAM_CTRL_STRIDE_EN
    logic [ADDR_W-1:0] r_rd_stride;
    logic [ADDR_W-1:0] r_wr_stride;

    assign w_rs = r_rd_stride;
    assign w_ws = r_wr_stride;
`else
    assign w_rs = ADDR_W'(1);
    assign w_ws = ADDR_W'(1);
`endif

    // An element is issued on the accepting edge and on every RUN edge until len are out.
    assign w_issue     = ((r_state == S_IDLE) && bus.start && (bus.len != '0)) ||
                         ((r_state == S_RUN) && (r_k != r_len));
    assign w_issue_idx = (r_state == S_IDLE) ? '0 : r_k;

    // Truncating the index first keeps the product modulo 2^ADDR_W, same as the full product.
    assign w_wr_idx = ADDR_W'(r_pipe_idx[RD_LAT-1]);
    assign w_wr_off = w_wr_idx * w_ws;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_base <= '0;
            r_len     <= '0;
            r_k       <= '0;
`ifdef VEC_STREAM_CTRL_STRIDE_EN
            r_rd_stride <= '0;
            r_wr_stride <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= w_issue;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                            r_len     <= bus.len;
                            r_k       <= LEN_W'(1);
                            r_rd_addr <= bus.rd_base;
                            r_wr_base <= bus.wr_base;
`ifdef VEC_STREAM_CTRL_STRIDE_EN
                            r_rd_stride <= bus.rd_stride;
                            r_wr_stride <= bus.wr_stride;
`endif
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_rd_addr <= r_rd_addr + w_rs;
                        r_k       <= r_k + LEN_W'(1);
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Empty pipeline here means the final wr_en is on the bus this cycle.
                    if (r_pipe_vld == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            // NOTE: the index stages are tiny, so they are reset with the valids rather than left as X.
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_idx[0] <= w_issue_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
            r_wr_en <= r_pipe_vld[RD_LAT-1];
            if (r_pipe_vld[RD_LAT-1]) begin
                r_wr_addr <= r_wr_base + w_wr_off;
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
endmodule
